// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Constants and types shared by the instruction-fetch stage of the 3-stage
// RV32I core:
//   FETCH_XLEN      - datapath and PC width
//   FETCH_RESET_PC  - byte address of the first instruction after reset
//   FETCH_NOP_INSTR - canonical NOP (addi x0,x0,0) placed in killed slots
//   fetch_state_e   - fetch sequencing states (S_RESET, S_FILL, S_RUN)
// Opcode constants live in the core's opcode header, not here.
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int          FETCH_XLEN      = 32;
    localparam logic [31:0] FETCH_RESET_PC  = 32'h4000_0000;
    localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2
    } fetch_state_e;

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_pc_gen.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen
// Next-PC priority mux plus the PC register of the fetch stage.
// Ports:
//   clk            in   core clock
//   rst            in   synchronous active-high reset
//   restart        in   sequencer is in S_RESET: restart fetching at RESET_PC
//   redirect_valid in   taken branch/jump resolved downstream this cycle
//   redirect_pc    in   redirect target (low two bits ignored)
//   hold           in   re-read the current word (stall or pipeline fill)
//   next_pc        out  address issued to instruction memory this cycle
//   pc_reg         out  address issued last cycle = PC of the word on imem_rdata
// ---------------------------------------------------------------------------
module fetch_pc_gen
    import fetch_stage_pkg::*;
#(
    parameter int             XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            restart,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            hold,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_reg
);

    logic [XLEN-1:0] redirect_target;

    // Targets are always word aligned; masking keeps every bit of the input in use.
    assign redirect_target = redirect_pc & ~XLEN'(3);

    // Next-PC selection in strict priority order: reset/restart, redirect,
    // hold (re-read the same word), then sequential +4 which wraps silently.
    always_comb begin
        next_pc = pc_reg + XLEN'(4);
        if (rst || restart) begin
            next_pc = RESET_PC;
        end else if (redirect_valid) begin
            next_pc = redirect_target;
        end else if (hold) begin
            next_pc = pc_reg;
        end
    end

    // pc_reg follows the issued address every cycle so it always names the
    // word that the synchronous memory returns in the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= next_pc;
        end
    end

endmodule : fetch_pc_gen

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the 3-stage RV32I core; feeds pre-decode.
// Owns the PC, the synchronous-read instruction-memory interface, and the
// kill logic that replaces wrong-path or not-yet-valid slots with a NOP.
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   stall           downstream hold: freeze PC, re-present the current word
//   redirect_valid  taken branch/jump this cycle, target on redirect_pc
//   imem_addr/en    address and read enable to instruction memory
//   imem_rdata      instruction word, valid one cycle after the address
//   instr, Opcode   instruction (or NOP) and its opcode field to pre-decode
//   pc_out          PC of the word on instr
//   instr_valid     instr is a real on-path instruction
//   fetch_cnt       delivered-instruction counter (FETCH_PERF_CNT_EN)
//   bubble_cnt      killed-slot counter while running (FETCH_PERF_CNT_EN)
// Build option: define FETCH_PERF_CNT_EN to build the performance counters;
// otherwise both counter ports read zero and no counter flops exist.
// ---------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN      = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(FETCH_RESET_PC),
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(FETCH_NOP_INSTR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_en,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      Opcode,
    output logic [XLEN-1:0] pc_out,
    output logic            instr_valid,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     bubble_cnt
);

    fetch_state_e    state;
    fetch_state_e    next_state;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pc_reg;
    logic            kill;

    // State register: reset wins from any state, even mid-stall or mid-redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Sequencing: one cycle to issue RESET_PC, one fill cycle while that word
    // is read, then run forever.
    always_comb begin
        next_state = state;
        case (state)
            S_RESET: next_state = S_FILL;
            S_FILL:  next_state = S_RUN;
            S_RUN:   next_state = S_RUN;
            default: next_state = S_RESET;
        endcase
    end

    // During the fill cycle the word on imem_rdata is killed, so the same
    // address is re-read to deliver RESET_PC as the first valid instruction.
    // A redirect during fill still takes priority inside the PC generator.
    fetch_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk            (clk),
        .rst            (rst),
        .restart        (state == S_RESET),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .hold           (stall || (state == S_FILL)),
        .next_pc        (next_pc),
        .pc_reg         (pc_reg)
    );

    // A slot is killed before the pipe is running, when a redirect makes the
    // word on imem_rdata wrong-path, and while reset is asserted.
    always_comb begin
        kill        = rst || (state != S_RUN) || redirect_valid;
        instr       = kill ? NOP_INSTR : imem_rdata;
        instr_valid = !kill;
        pc_out      = rst ? RESET_PC : pc_reg;
        imem_addr   = next_pc;
        imem_en     = 1'b1;
    end

    assign Opcode = instr[6:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    // Delivered instructions count once each (not per stalled repeat);
    // bubbles count killed slots only once the pipe is running.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            if (instr_valid && !stall) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((state == S_RUN) && kill) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign fetch_cnt  = 32'd0;
    assign bubble_cnt = 32'd0;
`endif

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. A synchronous memory model returns an
// address-derived word; a cycle-level reference model predicts every output
// and pushes it to a scoreboard that a separate monitor pops and compares.
// Honors FETCH_PERF_CNT_EN for the counter expectations.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] fcnt;
        logic [31:0] bcnt;
    } expect_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic [6:0]  Opcode;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;

    expect_t     sb[$];
    int          checks = 0;
    int          passes = 0;

    int          m_since = 0;
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_fetch = 32'd0;
    logic [31:0] m_bubble = 32'd0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .Opcode         (Opcode),
        .pc_out         (pc_out),
        .instr_valid    (instr_valid),
        .fetch_cnt      (fetch_cnt),
        .bubble_cnt     (bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Synchronous-read instruction memory.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        else
            passes++;
    endtask

    // Drive one cycle of inputs and predict that cycle's outputs from the
    // fetch rules: cycles since reset release, current slot PC, counters.
    task automatic applyStimulus(input logic r, input logic s, input logic rv,
                                 input logic [31:0] rp);
        expect_t     e;
        logic        running;
        logic [31:0] nxt;
        @(posedge clk);
        #1;
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
        e.fcnt = m_fetch;
        e.bcnt = m_bubble;
        if (r) begin
            e.addr = RESET_PC; e.instr = NOP; e.valid = 1'b0; e.pc = RESET_PC;
            sb.push_back(e);
            m_since = 0; m_pc = RESET_PC; m_fetch = 32'd0; m_bubble = 32'd0;
        end else begin
            running = (m_since >= 2);
            e.valid = running && !rv;
            e.instr = e.valid ? mem_word(m_pc) : NOP;
            e.pc    = m_pc;
            if (m_since == 0)         nxt = RESET_PC;
            else if (rv)              nxt = {rp[31:2], 2'b00};
            else if (!running || s)   nxt = m_pc;
            else                      nxt = m_pc + 32'd4;
            e.addr = nxt;
            sb.push_back(e);
            if (PERF && e.valid && !s) m_fetch  = m_fetch + 32'd1;
            if (PERF && running && !e.valid) m_bubble = m_bubble + 32'd1;
            m_pc = nxt;
            if (m_since < 2) m_since++;
        end
    endtask

    // Monitor: every cycle has an output slot, compared mid-cycle.
    always @(negedge clk) begin
        expect_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("imem_addr", imem_addr, e.addr);
            checkOutput("imem_en", {31'd0, imem_en}, 32'd1);
            checkOutput("instr", instr, e.instr);
            checkOutput("Opcode", {25'd0, Opcode}, {25'd0, e.instr[6:0]});
            checkOutput("instr_valid", {31'd0, instr_valid}, {31'd0, e.valid});
            checkOutput("pc_out", pc_out, e.pc);
            checkOutput("fetch_cnt", fetch_cnt, e.fcnt);
            checkOutput("bubble_cnt", bubble_cnt, e.bcnt);
        end
    end

    initial begin
        logic r, s, rv;
        logic [31:0] rp;
        $display("[TB] fetch_stage bench start, perf counters %0d", PERF);

        repeat (3) applyStimulus(1, 0, 0, 32'd0);
        repeat (4) applyStimulus(0, 0, 0, 32'd0);
        repeat (3) applyStimulus(0, 1, 0, 32'd0);
        repeat (2) applyStimulus(0, 0, 0, 32'd0);
        applyStimulus(0, 0, 1, 32'h4000_0103);
        repeat (2) applyStimulus(0, 0, 0, 32'd0);
        applyStimulus(0, 1, 1, 32'h4000_0200);
        repeat (2) applyStimulus(0, 0, 0, 32'd0);

        applyStimulus(1, 0, 1, 32'h4000_0500);
        applyStimulus(1, 0, 0, 32'd0);
        repeat (4) applyStimulus(0, 0, 0, 32'd0);
        applyStimulus(0, 0, 1, 32'hFFFF_FFFC);
        repeat (3) applyStimulus(0, 0, 0, 32'd0);
        applyStimulus(0, 0, 1, 32'h4000_1000);
        applyStimulus(0, 1, 1, 32'h4000_2002);
        applyStimulus(0, 0, 1, 32'h4000_3001);
        repeat (2) applyStimulus(0, 0, 0, 32'd0);

        applyStimulus(1, 0, 0, 32'd0);
        applyStimulus(0, 0, 0, 32'd0);
        applyStimulus(0, 0, 1, 32'h4000_0300);
        repeat (3) applyStimulus(0, 0, 0, 32'd0);

        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 5) == 0);
            rp = $urandom;
            if ($urandom_range(0, 7) == 0) rp = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            applyStimulus(r, s, rv, rp);
        end

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0)
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        else
            passes++;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 3-stage RV32I core. It sits directly upstream of the pre-decode stage and drives that stage's instr and Opcode inputs.
- Owns the PC register, next-PC selection and the synchronous-read instruction-memory address and enable.
- Kills wrong-path and invalid slots by substituting a canonical NOP.
- Handles reset fill, stall hold and branch/jump redirect.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h4000_0000, byte address of the first instruction fetched after reset.
- NOP_INSTR, 32'h0000_0013, encoding injected into killed slots (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  downstream hold: freeze PC and re-present the current instruction.
- redirect_valid  in  1  taken branch/jump resolved downstream this cycle.
- redirect_pc  in  XLEN  target byte address; bits [1:0] are ignored and treated as 0.
- imem_addr  out  XLEN  byte address issued to the instruction memory.
- imem_en  out  1  instruction-memory read enable.
- imem_rdata  in  XLEN  instruction word; valid one cycle after the address and enable are issued.
- instr  out  XLEN  instruction to pre-decode (NOP_INSTR when killed).
- Opcode  out  7  instr[6:0].
- pc_out  out  XLEN  PC of the word on instr.
- instr_valid  out  1  high when instr is a real, on-path instruction.
- fetch_cnt  out  32  performance counter; zero unless the optional feature is enabled.
- bubble_cnt  out  32  performance counter; zero unless the optional feature is enabled.

Behaviour:
- State machine, 2-bit: S_RESET, S_FILL, S_RUN.
  - rst=1 forces S_RESET from any state, including mid-stall or mid-redirect.
  - S_RESET goes to S_FILL on the first cycle with rst=0.
  - S_FILL goes to S_RUN unconditionally.
  - S_RUN stays in S_RUN.
- Registers: pc_reg is the address issued in the previous cycle, i.e. the PC of the data on imem_rdata.
- Output values during reset (rst=1):
  - pc_reg<=RESET_PC.
  - instr=NOP_INSTR, instr_valid=0, pc_out=RESET_PC.
  - Counters cleared to 0.
- Next-PC selection, combinational, in priority order:
  1. rst or S_RESET: RESET_PC.
  2. redirect_valid: {redirect_pc[XLEN-1:2],2'b00}.
  3. stall: pc_reg (re-read of the same word).
  4. Otherwise: pc_reg+4, wrapping modulo 2^XLEN with no flag.
- imem_addr = next_pc. imem_en=1 in every cycle, including reset.
- pc_reg<=next_pc every cycle.
- kill = (state!=S_RUN) | redirect_valid.
  - instr = kill ? NOP_INSTR : imem_rdata.
  - instr_valid = ~kill.
  - pc_out = pc_reg.
- Latency:
  - First valid instruction, PC=RESET_PC, appears 2 cycles after rst falls: first the S_FILL cycle, then the S_RUN cycle.
  - Redirect costs exactly 1 bubble: the slot in the redirect cycle is killed, and the target word appears the following cycle.
- Stall: instr, pc_out and instr_valid are held stable for every stalled cycle, because the same address is re-read.
- Simultaneous redirect_valid and stall: redirect wins, and the target is fetched.
- Back-to-back redirects: each one kills its own cycle. The final target is valid the cycle after the last redirect.
- Redirect during S_FILL: accepted; the target is fetched and the FSM still moves to S_RUN.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - fetch_cnt increments on every cycle with instr_valid=1 and stall=0.
  - bubble_cnt increments on every cycle with state==S_RUN and kill=1.
  - Both counters are 32-bit, wrap silently, and reset to 0.
- When undefined: both ports are tied to 32'd0 and no counter flops are synthesised.

Decomposition:
- Shared defines header:
  - `XLEN.
  - NOP_INSTR.
  - RESET_PC.
  - FSM state encodings S_RESET=2'd0, S_FILL=2'd1, S_RUN=2'd2.
- Opcode constants stay in the existing opcode header.
- One natural sub-module, fetch_pc_gen: the next-PC priority mux plus pc_reg. fetch_stage wraps it with the FSM, kill logic and counters.

Test Plan:
- Reset: hold rst 3 cycles, then release; memory returns addr-derived words.
  - imem_addr=0x4000_0000 during reset.
  - Cycle+1: instr=0x00000013, instr_valid=0.
  - Cycle+2: pc_out=0x4000_0000, instr_valid=1.
  - Cycle+3: pc_out=0x4000_0004.
- Stall: assert stall for 3 cycles at pc_out=0x4000_0008.
  - imem_addr stays 0x4000_0008.
  - instr and pc_out are held; instr_valid=1 throughout.
  - After release, the next pc_out is 0x4000_000C.
- Redirect: redirect_valid=1 with redirect_pc=0x4000_0103 at pc_out=0x4000_0010.
  - That cycle: instr=NOP, instr_valid=0, imem_addr=0x4000_0100.
  - Next cycle: pc_out=0x4000_0100, instr_valid=1.
- Simultaneous stall and redirect to 0x4000_0200: the target is fetched; one bubble; pc_out=0x4000_0200 next cycle.
- Reset mid-redirect, with rst and redirect_valid both high: imem_addr=RESET_PC and the FSM returns to S_RESET.
  - With FETCH_PERF_CNT_EN defined, both counters read 0.
- Wrap-around: redirect to 0xFFFF_FFFC, then run 2 cycles: pc_out goes 0xFFFF_FFFC then 0x0000_0000.
  - With FETCH_PERF_CNT_EN defined, bubble_cnt increments by 1.
